// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, ALUOp encodings, the hazard
// sequencer state enum, the bubble control word and the hazard control vector.
package riscv_pkg;

    // Major opcodes seen by the decoder
    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_IALU = 7'b0010011;
    localparam logic [6:0] OPC_SD   = 7'b0100011;
    localparam logic [6:0] OPC_SB   = 7'b1100011;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;

    // ALUOp handed from the main decoder to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    // Hazard sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } hz_state_e;

    // Decoded control word carried down the pipeline
    typedef struct packed {
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   mem_to_reg;
        logic   alu_src;
        logic   branch;
        logic   jump;
        aluop_e alu_op;
    } ctrl_word_t;

    // A bubble has every control bit cleared so it cannot change state
    localparam ctrl_word_t BUBBLE_CTRL = ctrl_word_t'(9'b0_0000_0000);

    // Enables/flushes driven by the hazard sequencer, in port order
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_flush;
        logic mem_err;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_ADVANCE  = hz_ctl_t'(8'b1101_0100);
    localparam hz_ctl_t CTL_REDIRECT = hz_ctl_t'(8'b1111_1100);
    localparam hz_ctl_t CTL_BUBBLE   = hz_ctl_t'(8'b0001_1100);
    localparam hz_ctl_t CTL_FREEZE   = hz_ctl_t'(8'b0000_0010);
    localparam hz_ctl_t CTL_ERROR    = hz_ctl_t'(8'b0000_0011);

    // True when a producer rd feeds a consumer rs; x0 never creates a dependency
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a
// load currently in EX (the value is not available until after MEM).
module load_use_detect
    import riscv_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       lu_hazard
);

    // Load in EX whose rd matches rs1, or rs2 when the ID instruction reads it
    always_comb begin
        lu_hazard = 1'b0;
        if (ex_mem_read) begin
            lu_hazard = reg_match(ex_rd, id_rs1) | (id_uses_rs2 & reg_match(ex_rd, id_rs2));
        end else begin
            lu_hazard = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Handles load-use bubbles, EX redirects, data-memory waits and a memory
// watchdog (MEM_TIMEOUT = 0 disables it).
// Optional build macro PIPE_HAZARD_PERF_CNT_EN adds saturating stall/flush
// performance counters; without it both counter ports read zero.
module pipeline_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Counter holds the number of frozen cycles of the current memory wait
    localparam int             TO_W    = $clog2(MEM_TIMEOUT + 2);
    localparam logic           WDOG_EN = (MEM_TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    hz_state_e       state_r;
    hz_state_e       state_nxt_s;
    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_cnt_nxt_s;
    logic            lu_hazard_s;
    logic            mem_hold_s;
    logic            run_eval_s;
    hz_ctl_t         ctl_s;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .lu_hazard   (lu_hazard_s)
    );

    assign mem_hold_s = mem_req & ~dmem_ready;

    // Next-state, watchdog count and control vector from state and inputs
    always_comb begin
        ctl_s        = CTL_ADVANCE;
        state_nxt_s  = state_r;
        to_cnt_nxt_s = to_cnt_r;
        run_eval_s   = 1'b0;

        case (state_r)
            RUN: begin
                run_eval_s = 1'b1;
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    // Access done: the frozen ID/EX contents are judged now
                    state_nxt_s  = RUN;
                    to_cnt_nxt_s = {TO_W{1'b0}};
                    run_eval_s   = 1'b1;
                end else begin
                    ctl_s = CTL_FREEZE;
                    if (WDOG_EN && (to_cnt_r >= TO_LAST)) begin
                        state_nxt_s = ERR;
                    end else if (to_cnt_r != TO_MAX) begin
                        to_cnt_nxt_s = to_cnt_r + TO_ONE;
                    end else begin
                        to_cnt_nxt_s = to_cnt_r;
                    end
                end
            end
            ERR: begin
                ctl_s = CTL_ERROR;
            end
            default: begin
                ctl_s        = CTL_ERROR;
                state_nxt_s  = ERR;
                to_cnt_nxt_s = {TO_W{1'b0}};
            end
        endcase

        if (run_eval_s) begin
            if (mem_hold_s) begin
                ctl_s        = CTL_FREEZE;
                state_nxt_s  = MEM_WAIT;
                to_cnt_nxt_s = TO_ONE;
            end else if (ex_redirect) begin
                // ID instruction is squashed, so any load-use hazard is moot
                ctl_s = CTL_REDIRECT;
            end else if (lu_hazard_s) begin
                ctl_s = CTL_BUBBLE;
            end else begin
                ctl_s = CTL_ADVANCE;
            end
        end else begin
            ctl_s = ctl_s;
        end
    end

    // While reset is held the pipeline runs freely with no error indication
    always_comb begin
        if (reset) begin
            {pc_write, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_write, mem_wb_flush, mem_err} = CTL_ADVANCE;
        end else begin
            {pc_write, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_write, mem_wb_flush, mem_err} = ctl_s;
        end
    end

    // State and watchdog counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= RUN;
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            to_cnt_r <= to_cnt_nxt_s;
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             stall_evt_s;
    logic             flush_evt_s;

    assign stall_evt_s = ~ctl_s.pc_write & (state_r != ERR);
    assign flush_evt_s = ctl_s.if_id_flush;

    // Saturating performance counters for stall cycles and acted-on redirects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios followed by random
// stimulus, every cycle compared with a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
    logic          id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_redirect = 1'b0;
    logic          mem_req = 1'b0, dmem_ready = 1'b1;
    logic          pc_write, if_id_write, if_id_flush, id_ex_write;
    logic          id_ex_flush, ex_mem_write, mem_wb_flush, mem_err;
    logic [CW-1:0] stall_cycles, flush_count;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Model: are we inside a memory wait, how long has it lasted, is error latched
    bit m_wait = 1'b0;
    int m_wait_len = 0;
    bit m_err = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    typedef enum int { ACT_ADVANCE, ACT_REDIRECT, ACT_BUBBLE, ACT_FREEZE, ACT_ERROR } act_e;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs2  (id_uses_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .mem_wb_flush (mem_wb_flush),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {pc_write,if_id_write,if_id_flush,id_ex_write,id_ex_flush,ex_mem_write,mem_wb_flush,mem_err}
    function automatic logic [7:0] act_vec(input act_e a);
        case (a)
            ACT_REDIRECT: return 8'b1111_1100;
            ACT_BUBBLE:   return 8'b0001_1100;
            ACT_FREEZE:   return 8'b0000_0010;
            ACT_ERROR:    return 8'b0000_0011;
            default:      return 8'b1101_0100;
        endcase
    endfunction

    // One clock: drive at negedge, compare, then advance the model at posedge
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic mr, input logic [4:0] rd, input logic rdr,
                        input logic mrq, input logic rdy, input logic rst);
        act_e act;
        logic [7:0] exp;
        bit lu;
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_mem_read = mr; ex_rd = rd;
        ex_redirect = rdr; mem_req = mrq; dmem_ready = rdy; reset = rst;
        #1;
        lu = mr && (rd != 5'd0) && ((rd == rs1) || (u2 && (rd == rs2)));
        if (m_err)                        act = ACT_ERROR;
        else if (m_wait && !rdy)          act = ACT_FREEZE;
        else if (!m_wait && mrq && !rdy)  act = ACT_FREEZE;
        else if (rdr)                     act = ACT_REDIRECT;
        else if (lu)                      act = ACT_BUBBLE;
        else                              act = ACT_ADVANCE;
        if (rst) begin
            m_wait = 1'b0; m_wait_len = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
            exp = act_vec(ACT_ADVANCE);
        end else begin
            exp = act_vec(act);
        end
        check("ctl", {24'd0, pc_write, if_id_write, if_id_flush, id_ex_write,
                      id_ex_flush, ex_mem_write, mem_wb_flush, mem_err}, {24'd0, exp});
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_count", flush_count, m_flush);
`else
        check("stall_cycles", stall_cycles, 32'd0);
        check("flush_count", flush_count, 32'd0);
`endif
        @(posedge clk);
        if (!rst) begin
            if (act == ACT_FREEZE || act == ACT_BUBBLE) m_stall++;
            if (act == ACT_REDIRECT) m_flush++;
            if (act == ACT_FREEZE) begin
                m_wait = 1'b1;
                m_wait_len++;
                if (m_wait_len == TIMEOUT) begin
                    m_err = 1'b1;
                    m_wait = 1'b0;
                end
            end else begin
                m_wait = 1'b0;
                m_wait_len = 0;
            end
        end
    endtask

    initial begin
        // Reset held: free-running outputs even with hazardous inputs
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // ld x5 ; add x6,x5,x7 -> one bubble, then advance
        step(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        step(5'd5, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // ld x0 with ID reading x0 -> no stall; sd rs2=x5 after ld x5 -> stall
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        // rs2 match ignored when rs2 is not read
        step(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        // Redirect wins over load-use
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);

        // Memory wait of 3 cycles, redirect raised during it, acted on at ready
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        // Ready on the timeout cycle wins: 3 frozen cycles then ready
        for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("no_err_on_ready", {31'd0, mem_err}, 32'd0);

        // Watchdog: ready never comes -> ERR after 4 wait cycles, sticky
        for (int i = 0; i < 4; i++) step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("err_sticky", {31'd0, mem_err}, 32'd1);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Counters: 2 load-use stalls and 1 redirect after a fresh reset
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        step(5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(5'd9, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        step(5'd9, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check("perf_stall", stall_cycles, 32'd2);
        check("perf_flush", flush_count, 32'd1);
`else
        check("perf_stall", stall_cycles, 32'd0);
        check("perf_flush", flush_count, 32'd0);
`endif

        // Random traffic over a small register set so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            logic mrq_v, rdy_v;
            mrq_v = ($urandom_range(0, 2) == 0);
            rdy_v = ($urandom_range(0, 9) < 6);
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), mrq_v, rdy_v, ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
